// File: rtl/stream_demux_1_2.sv
// 1-to-2 stream demultiplexer with a 2-entry skid FIFO and packet-safe, guarded destination switching.
// Optional build macro DEMUX_STALL_CNT_EN adds an 8-bit saturating upstream stall counter (STALL_CNT).
module stream_demux_1_2 #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              SEL_REQ,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic [DATA_W-1:0] Y0_DATA,
  output logic              Y0_VALID,
  output logic              Y0_LAST,
  input  logic              Y0_READY,
  output logic [DATA_W-1:0] Y1_DATA,
  output logic              Y1_VALID,
  output logic              Y1_LAST,
  input  logic              Y1_READY,
  output logic              SEL_CUR,
  output logic              SWITCH_PEND
`ifdef DEMUX_STALL_CNT_EN
  ,
  output logic [7:0]        STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    ROUTE = 2'd0,
    DRAIN = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC);

  state_t            state_q, state_d;
  logic [3:0]        guard_q, guard_d;
  logic              sel_cur_q, sel_cur_d;
  logic              pkt_open_q;
  logic              run_q;
  logic              switch_pend_q;

  logic [DATA_W-1:0] mem_data [2];
  logic              mem_last [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              fifo_full, fifo_empty, sel_diff;
  logic              arm, in_ready, head_valid, push, pop;

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign sel_diff   = (SEL_REQ != sel_cur_q);

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    sel_cur_d = sel_cur_q;
    arm       = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      ROUTE: begin
        // An open packet holds off the switch until its LAST beat is taken.
        arm      = sel_diff && !pkt_open_q;
        in_ready = run_q && !fifo_full && !arm;
        if (arm) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          guard_d = GUARD_INIT;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (guard_q <= 4'd1) begin
          guard_d   = '0;
          sel_cur_d = SEL_REQ;
          state_d   = ROUTE;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = ROUTE;
    endcase
  end

  assign head_valid = !fifo_empty && (state_q != GUARD);
  assign push       = IN_VALID && in_ready;
  assign pop        = head_valid && (sel_cur_q ? Y1_READY : Y0_READY);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q       <= ROUTE;
      guard_q       <= '0;
      sel_cur_q     <= 1'b0;
      pkt_open_q    <= 1'b0;
      run_q         <= 1'b0;
      switch_pend_q <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      sel_cur_q     <= sel_cur_d;
      run_q         <= 1'b1;
      switch_pend_q <= sel_diff || (state_q != ROUTE);
      if (push) begin
        mem_data[wr_ptr_q] <= IN_DATA;
        mem_last[wr_ptr_q] <= IN_LAST;
        wr_ptr_q           <= ~wr_ptr_q;
        pkt_open_q         <= !IN_LAST;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DEMUX_STALL_CNT_EN
  logic [7:0] stall_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      stall_q <= '0;
    end else if (IN_VALID && !in_ready && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign STALL_CNT = stall_q;
`endif

  assign IN_READY    = in_ready;
  assign Y0_DATA     = mem_data[rd_ptr_q];
  assign Y1_DATA     = mem_data[rd_ptr_q];
  assign Y0_LAST     = mem_last[rd_ptr_q];
  assign Y1_LAST     = mem_last[rd_ptr_q];
  assign Y0_VALID    = head_valid && !sel_cur_q;
  assign Y1_VALID    = head_valid && sel_cur_q;
  assign SEL_CUR     = sel_cur_q;
  assign SWITCH_PEND = switch_pend_q;

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed self-checking bench for stream_demux_1_2 (DATA_W=16, GUARD_CYC=2).
module tb_stream_demux_1_2;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        SEL_REQ;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_LAST;
  logic        IN_READY;
  logic [15:0] Y0_DATA;
  logic        Y0_VALID;
  logic        Y0_LAST;
  logic        Y0_READY;
  logic [15:0] Y1_DATA;
  logic        Y1_VALID;
  logic        Y1_LAST;
  logic        Y1_READY;
  logic        SEL_CUR;
  logic        SWITCH_PEND;
`ifdef DEMUX_STALL_CNT_EN
  logic [7:0]  STALL_CNT;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  stream_demux_1_2 #(.DATA_W(16), .GUARD_CYC(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .SEL_REQ(SEL_REQ),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .Y0_DATA(Y0_DATA), .Y0_VALID(Y0_VALID), .Y0_LAST(Y0_LAST), .Y0_READY(Y0_READY),
    .Y1_DATA(Y1_DATA), .Y1_VALID(Y1_VALID), .Y1_LAST(Y1_LAST), .Y1_READY(Y1_READY),
    .SEL_CUR(SEL_CUR), .SWITCH_PEND(SWITCH_PEND)
`ifdef DEMUX_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle; outputs are sampled and inputs driven here.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESETN = 1'b0; SEL_REQ = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; IN_LAST = 1'b0;
    Y0_READY = 1'b1; Y1_READY = 1'b1;
    repeat (3) step();
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", IN_READY); end
    n_vec++; if ({Y0_VALID, Y1_VALID} !== 2'b00) begin n_err++; $display("FAIL rst_valids got %b want 00", {Y0_VALID, Y1_VALID}); end
    n_vec++; if (SEL_CUR !== 1'b0) begin n_err++; $display("FAIL rst_sel_cur got %b want 0", SEL_CUR); end
    n_vec++; if (SWITCH_PEND !== 1'b0) begin n_err++; $display("FAIL rst_switch_pend got %b want 0", SWITCH_PEND); end
    n_vec++; if ({Y0_DATA, Y0_LAST} !== 17'h0) begin n_err++; $display("FAIL rst_y0_data got %h/%b want 0/0", Y0_DATA, Y0_LAST); end
`ifdef DEMUX_STALL_CNT_EN
    n_vec++; if (STALL_CNT !== 8'd0) begin n_err++; $display("FAIL rst_stall_cnt got %0d want 0", STALL_CNT); end
`endif
    RESETN = 1'b1;
    #1;
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_ready_early got %b want 0", IN_READY); end
    step();
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise got %b want 1", IN_READY); end
  endtask

  task automatic test_single_beats;
    logic [15:0] d;
    SEL_REQ = 1'b0; Y0_READY = 1'b1; Y1_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 16'(i);
      IN_VALID = 1'b1; IN_DATA = d; IN_LAST = 1'b1;
      #1;
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL single_ready[%0d] got %b want 1", i, IN_READY); end
      step();
      n_vec++; if ({Y0_VALID, Y0_DATA, Y0_LAST} !== {1'b1, d, 1'b1}) begin n_err++; $display("FAIL single_y0[%0d] got v%b d%h l%b want v1 d%h l1", i, Y0_VALID, Y0_DATA, Y0_LAST, d); end
      n_vec++; if (Y1_VALID !== 1'b0) begin n_err++; $display("FAIL single_y1v[%0d] got %b want 0", i, Y1_VALID); end
      n_vec++; if (Y1_DATA !== d) begin n_err++; $display("FAIL single_y1d[%0d] got %h want %h", i, Y1_DATA, d); end
    end
    IN_VALID = 1'b0;
    step();
    n_vec++; if ({Y0_VALID, Y1_VALID} !== 2'b00) begin n_err++; $display("FAIL single_idle got %b want 00", {Y0_VALID, Y1_VALID}); end
  endtask

  task automatic test_backpressure;
    Y0_READY = 1'b0;
    IN_VALID = 1'b1; IN_LAST = 1'b1; IN_DATA = 16'h0010;
    step();
    IN_DATA = 16'h0011;
    step();
    IN_DATA = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_full_ready[%0d] got %b want 0", i, IN_READY); end
      n_vec++; if ({Y0_VALID, Y0_DATA} !== {1'b1, 16'h0010}) begin n_err++; $display("FAIL bp_head[%0d] got v%b d%h want v1 d0010", i, Y0_VALID, Y0_DATA); end
      step();
    end
    Y0_READY = 1'b1;
    step();
    n_vec++; if ({Y0_VALID, Y0_DATA} !== {1'b1, 16'h0011}) begin n_err++; $display("FAIL bp_rel1 got v%b d%h want v1 d0011", Y0_VALID, Y0_DATA); end
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_rel_ready got %b want 1", IN_READY); end
    step();
    n_vec++; if ({Y0_VALID, Y0_DATA} !== {1'b1, 16'h0012}) begin n_err++; $display("FAIL bp_rel2 got v%b d%h want v1 d0012", Y0_VALID, Y0_DATA); end
    IN_VALID = 1'b0;
    step();
    n_vec++; if (Y0_VALID !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", Y0_VALID); end
  endtask

  task automatic test_abort_switch;
    bit done;
    Y0_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 16'h0040; IN_LAST = 1'b1;
    step();
    IN_VALID = 1'b0; SEL_REQ = 1'b1;
    #1;
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL abort_arm_ready got %b want 0", IN_READY); end
    step();
    SEL_REQ = 1'b0;
    step();
    n_vec++; if ({Y0_VALID, Y0_DATA, Y1_VALID} !== {1'b1, 16'h0040, 1'b0}) begin n_err++; $display("FAIL abort_drain got y0v%b d%h y1v%b want 1 0040 0", Y0_VALID, Y0_DATA, Y1_VALID); end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL abort_drain_ready got %b want 0", IN_READY); end
    Y0_READY = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      n_vec++; if (Y1_VALID !== 1'b0) begin n_err++; $display("FAIL abort_y1_leak[%0d] got %b want 0", k, Y1_VALID); end
      if (IN_READY === 1'b1) done = 1'b1;
      else step();
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL abort_timeout got ready %b want 1 within 20 cycles", IN_READY); end
    n_vec++; if (SEL_CUR !== 1'b0) begin n_err++; $display("FAIL abort_sel_cur got %b want 0", SEL_CUR); end
    IN_VALID = 1'b1; IN_DATA = 16'h0041; IN_LAST = 1'b1;
    step();
    n_vec++; if ({Y0_VALID, Y0_DATA, Y1_VALID} !== {1'b1, 16'h0041, 1'b0}) begin n_err++; $display("FAIL abort_resume got y0v%b d%h y1v%b want 1 0041 0", Y0_VALID, Y0_DATA, Y1_VALID); end
    IN_VALID = 1'b0;
    step();
  endtask

  task automatic test_switch_mid_packet;
    logic [15:0] d;
    int unsigned zeros;
    bit done;
    Y0_READY = 1'b1; Y1_READY = 1'b1; SEL_REQ = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d = 16'h0020 + 16'(i);
      IN_VALID = 1'b1; IN_DATA = d; IN_LAST = (i == 4);
      if (i == 2) SEL_REQ = 1'b1;
      #1;
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL sw_pkt_ready[%0d] got %b want 1", i, IN_READY); end
      step();
      n_vec++; if ({Y0_VALID, Y0_DATA, Y1_VALID} !== {1'b1, d, 1'b0}) begin n_err++; $display("FAIL sw_pkt_y0[%0d] got y0v%b d%h y1v%b want 1 %h 0", i, Y0_VALID, Y0_DATA, Y1_VALID, d); end
    end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL sw_arm_ready got %b want 0", IN_READY); end
    IN_VALID = 1'b1; IN_DATA = 16'h0030; IN_LAST = 1'b1;
    step();
    n_vec++; if ({SWITCH_PEND, Y0_VALID, IN_READY} !== 3'b100) begin n_err++; $display("FAIL sw_drain got pend%b y0v%b rdy%b want 1 0 0", SWITCH_PEND, Y0_VALID, IN_READY); end
    zeros = 2;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      n_vec++; if ({Y0_VALID, Y1_VALID} !== 2'b00) begin n_err++; $display("FAIL sw_guard_valid[%0d] got %b want 00", k, {Y0_VALID, Y1_VALID}); end
      if (IN_READY === 1'b1) done = 1'b1;
      else begin step(); zeros++; end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL sw_timeout got ready %b want 1 within 20 cycles", IN_READY); end
    n_vec++; if (zeros < 2) begin n_err++; $display("FAIL sw_guard_len got %0d want >=2", zeros); end
    n_vec++; if (SEL_CUR !== 1'b1) begin n_err++; $display("FAIL sw_sel_cur got %b want 1", SEL_CUR); end
    step();
    n_vec++; if ({Y1_VALID, Y1_DATA, Y1_LAST, Y0_VALID} !== {1'b1, 16'h0030, 1'b1, 1'b0}) begin n_err++; $display("FAIL sw_y1 got y1v%b d%h l%b y0v%b want 1 0030 1 0", Y1_VALID, Y1_DATA, Y1_LAST, Y0_VALID); end
    n_vec++; if (SWITCH_PEND !== 1'b0) begin n_err++; $display("FAIL sw_pend_clear got %b want 0", SWITCH_PEND); end
    IN_VALID = 1'b0;
    step();
    n_vec++; if (Y1_VALID !== 1'b0) begin n_err++; $display("FAIL sw_y1_empty got %b want 0", Y1_VALID); end
  endtask

  task automatic test_reset_mid_switch;
    Y1_READY = 1'b0;
    IN_VALID = 1'b1; IN_LAST = 1'b1; IN_DATA = 16'h0050;
    step();
    IN_DATA = 16'h0051;
    step();
    n_vec++; if ({IN_READY, Y1_VALID, Y1_DATA} !== {1'b0, 1'b1, 16'h0050}) begin n_err++; $display("FAIL rms_full got rdy%b y1v%b d%h want 0 1 0050", IN_READY, Y1_VALID, Y1_DATA); end
    IN_VALID = 1'b0; SEL_REQ = 1'b0;
    step();
    n_vec++; if ({SWITCH_PEND, Y1_VALID} !== 2'b11) begin n_err++; $display("FAIL rms_pending got pend%b y1v%b want 1 1", SWITCH_PEND, Y1_VALID); end
    RESETN = 1'b0;
    step();
    n_vec++; if ({Y0_VALID, Y1_VALID, SEL_CUR, IN_READY, SWITCH_PEND} !== 5'b00000) begin n_err++; $display("FAIL rms_reset got %b want 00000", {Y0_VALID, Y1_VALID, SEL_CUR, IN_READY, SWITCH_PEND}); end
    n_vec++; if ({Y1_DATA, Y1_LAST} !== 17'h0) begin n_err++; $display("FAIL rms_data got %h/%b want 0/0", Y1_DATA, Y1_LAST); end
    RESETN = 1'b1; Y1_READY = 1'b1;
    step();
    n_vec++; if ({IN_READY, Y0_VALID, Y1_VALID} !== 3'b100) begin n_err++; $display("FAIL rms_after got %b want 100", {IN_READY, Y0_VALID, Y1_VALID}); end
    IN_VALID = 1'b1; IN_DATA = 16'h0060; IN_LAST = 1'b1;
    step();
    n_vec++; if ({Y0_VALID, Y0_DATA, Y0_LAST} !== {1'b1, 16'h0060, 1'b1}) begin n_err++; $display("FAIL rms_fresh got v%b d%h l%b want 1 0060 1", Y0_VALID, Y0_DATA, Y0_LAST); end
    IN_VALID = 1'b0;
    step();
    n_vec++; if (Y0_VALID !== 1'b0) begin n_err++; $display("FAIL rms_no_stale got %b want 0", Y0_VALID); end
  endtask

`ifdef DEMUX_STALL_CNT_EN
  task automatic test_stall_cnt;
    RESETN = 1'b0; IN_VALID = 1'b0; SEL_REQ = 1'b0;
    repeat (2) step();
    n_vec++; if (STALL_CNT !== 8'd0) begin n_err++; $display("FAIL stall_rst got %0d want 0", STALL_CNT); end
    RESETN = 1'b1; Y0_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 16'h0070; IN_LAST = 1'b1;
    repeat (300) step();
    n_vec++; if (STALL_CNT !== 8'd255) begin n_err++; $display("FAIL stall_sat got %0d want 255", STALL_CNT); end
    IN_VALID = 1'b0; Y0_READY = 1'b1;
    repeat (3) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_beats();
    test_backpressure();
    test_abort_switch();
    test_switch_mid_packet();
    test_reset_mid_switch();
`ifdef DEMUX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_2.md
STREAM_DEMUX_1_2 -- requirements
Module: stream_demux_1_2

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one sample beat.
REQ-002 SHALL have parameter GUARD_CYC, default 2: number of idle cycles inserted on a destination switch, legal range 1..15.
REQ-003 SHALL have port CLK  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port RESETN  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port SEL_REQ  input  1: requested destination, 0 = Y0, 1 = Y1; level, may change any cycle.
REQ-006 SHALL have ports IN_DATA  input  DATA_W, IN_VALID  input  1, IN_LAST  input  1: upstream beat, valid flag and end-of-packet marker.
REQ-007 SHALL have port IN_READY  output  1: upstream beat accepted when IN_VALID=1 and IN_READY=1 on the same edge.
REQ-008 SHALL have ports Yn_DATA  output  DATA_W, Yn_VALID  output  1, Yn_LAST  output  1, Yn_READY  input  1, for n = 0 and n = 1.
REQ-009 SHALL have port SEL_CUR  output  1: destination currently routed.
REQ-010 SHALL have port SWITCH_PEND  output  1: high while SEL_REQ != SEL_CUR or a switch is in progress.

Function
REQ-011 SHALL buffer accepted beats (data and last) in a 2-entry FIFO; the FIFO head is presented only on the SEL_CUR destination; the other destination's VALID SHALL be 0.
REQ-012 SHALL present Yn_DATA and Yn_LAST as the FIFO head on both outputs; only VALID is gated.
REQ-013 SHALL have a latency of 1 cycle: a beat accepted at edge k is valid at the output after edge k.
REQ-014 SHALL drive IN_READY=1 only in state ROUTE with the FIFO not full and no switch armed.
REQ-015 SHALL pop the FIFO on Yn_VALID=1 and Yn_READY=1; simultaneous push and pop with the FIFO full SHALL NOT be allowed, because IN_READY=0 when full.
REQ-016 SHALL track whether a packet is open: it is set on an accepted beat with IN_LAST=0 and cleared on an accepted beat with IN_LAST=1.
REQ-017 SHALL implement FSM states ROUTE, DRAIN and GUARD.
REQ-018 ROUTE: if SEL_REQ != SEL_CUR and no packet is open, the FSM SHALL arm the switch, drop IN_READY the same cycle and go to DRAIN. If a packet is open, it SHALL keep accepting until the LAST beat is accepted, then arm.
REQ-019 DRAIN: IN_READY SHALL be 0; the FSM SHALL remain until the FIFO is empty, then load the guard counter with GUARD_CYC and go to GUARD.
REQ-020 GUARD: both VALIDs SHALL be 0 and IN_READY SHALL be 0; the counter SHALL decrement each cycle. At 0, SEL_CUR SHALL be set to the SEL_REQ value sampled in that cycle and the FSM SHALL return to ROUTE.
REQ-021 If SEL_REQ returns to SEL_CUR during DRAIN or GUARD, the sequence SHALL still complete, SEL_CUR SHALL stay unchanged and the FSM SHALL return to ROUTE.
REQ-022 SWITCH_PEND SHALL be asserted when (SEL_REQ != SEL_CUR) or the state is not ROUTE, registered with 1-cycle delay.
REQ-023 SHALL never drop, duplicate or reorder beats, and SHALL never split a packet across destinations.

Reset
REQ-024 With RESETN=0 at an edge, the block SHALL reset to: state ROUTE, FIFO empty, packet-open 0, SEL_CUR 0, SWITCH_PEND 0, IN_READY 0, Y0_VALID 0, Y1_VALID 0, Yn_DATA 0, Yn_LAST 0, guard counter 0.
REQ-025 IN_READY SHALL rise on the first edge after RESETN deasserts.
REQ-026 A reset asserted mid-packet or mid-switch SHALL discard buffered beats; no partial state survives.

Configuration
REQ-027 With macro DEMUX_STALL_CNT_EN defined, the block SHALL add output STALL_CNT (8 bits): it increments each cycle with IN_VALID=1 and IN_READY=0, saturates at 255 and resets to 0.
REQ-028 With DEMUX_STALL_CNT_EN undefined, there SHALL be no STALL_CNT port and no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then 4 single-beat packets 0x0001..0x0004 with SEL_REQ=0 and Y0_READY=1 -> each appears on Y0 one cycle later; Y1_VALID is never 1.
REQ-030 Y0_READY=0 with continuous input -> 2 beats accepted, IN_READY=0 thereafter; release -> beats delivered in order, no loss.
REQ-031 SEL_REQ 0->1 during beat 2 of a 4-beat packet -> all 4 beats go to Y0, IN_READY=0 for at least GUARD_CYC=2 cycles, SEL_CUR=1, next packet goes to Y1.
REQ-032 SEL_REQ pulses 0->1->0 within DRAIN -> SEL_CUR stays 0, ROUTE resumes, no beat appears on Y1.
REQ-033 RESETN=0 with 2 beats buffered and a switch in progress -> next cycle all VALIDs 0, SEL_CUR 0, FIFO empty.
REQ-034 With DEMUX_STALL_CNT_EN defined, hold Y0_READY=0 with IN_VALID=1 for 300 cycles -> STALL_CNT=255.
